wishbone_arbiter: RTL and testbench

Multi-master Wishbone bus arbiter placed between N_MASTER wishbone_master instances and the wishbone_interconnect slave-side path. Grants the shared bus to one master at a time with round-robin fairness and routes that master's request signals to the shared bus and the slave response back to it. A bus watchdog terminates stalled cycles with an error response so that a missing slave cannot hang the system.

---
 rtl/wishbone_pkg.sv | 14 +
 rtl/wb_rr_pick.sv | 30 +++
 rtl/wishbone_arbiter.sv | 134 +++++++++++++
 tb/tb_wishbone_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone bus types and widths for the arbiter and interconnect blocks.
package wishbone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: the lowest requesting index at or after ptr
// wins, with the search wrapping from N-1 back to 0.
module wb_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin multi-master Wishbone arbiter with a bus watchdog that answers
// stalled strobes with an error so an absent slave cannot hang the bus.
module wishbone_arbiter
    import wishbone_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic [N_MASTER-1:0]            m_cyc_i,
    input  logic [N_MASTER-1:0]            m_stb_i,
    input  logic [N_MASTER-1:0]            m_we_i,
    input  logic [N_MASTER*WB_SEL_W-1:0]   m_sel_i,
    input  logic [N_MASTER*WB_ADR_W-1:0]   m_adr_i,
    input  logic [N_MASTER*WB_DAT_W-1:0]   m_dat_i,
    output logic [WB_DAT_W-1:0]            m_dat_o,
    output logic [N_MASTER-1:0]            m_ack_o,
    output logic [N_MASTER-1:0]            m_err_o,
    output logic [N_MASTER-1:0]            m_gnt_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [WB_SEL_W-1:0]            s_sel_o,
    output logic [WB_ADR_W-1:0]            s_adr_o,
    output logic [WB_DAT_W-1:0]            s_dat_o,
    input  logic [WB_DAT_W-1:0]            s_dat_i,
    input  logic                           s_ack_i,
    output logic                           busy_o,
    output arb_state_e                     state_o
);

    localparam int PTR_W = $clog2(N_MASTER);

    arb_state_e          state;
    logic [N_MASTER-1:0] gnt;
    logic [N_MASTER-1:0] pick_gnt;
    logic                pick_valid;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    g_idx;
    logic [PTR_W-1:0]    nxt_ptr;
    logic [PTR_W-1:0]    pick_ptr;
    logic [TO_W-1:0]     wd_cnt;
    logic                in_busy;
    logic                owner_cyc;
    logic                timeout_hit;

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (gnt[k]) g_idx = PTR_W'(k);
        end
    end

    assign nxt_ptr   = (int'(g_idx) == N_MASTER - 1) ? '0 : g_idx + PTR_W'(1);
    // On release the search restarts just past the outgoing owner.
    assign pick_ptr  = (state == IDLE) ? ptr : nxt_ptr;
    assign in_busy   = (state == BUSY);
    assign owner_cyc = m_cyc_i[g_idx];

    wb_rr_pick #(
        .N     (N_MASTER),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (pick_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign timeout_hit = (TIMEOUT != 0) && in_busy && s_stb_o && !s_ack_i &&
                         (wd_cnt == TO_W'(TIMEOUT - 1));

    assign s_cyc_o = in_busy & owner_cyc;
    assign s_stb_o = in_busy & m_stb_i[g_idx];
    assign s_we_o  = in_busy & m_we_i[g_idx];
    assign s_sel_o = in_busy ? m_sel_i[int'(g_idx)*WB_SEL_W +: WB_SEL_W] : '0;
    assign s_adr_o = in_busy ? m_adr_i[int'(g_idx)*WB_ADR_W +: WB_ADR_W] : '0;
    assign s_dat_o = in_busy ? m_dat_i[int'(g_idx)*WB_DAT_W +: WB_DAT_W] : '0;

    assign m_dat_o = in_busy ? s_dat_i : '0;
    assign m_ack_o = in_busy ? (gnt & {N_MASTER{s_ack_i}}) : '0;
    assign m_err_o = timeout_hit ? gnt : '0;
    assign m_gnt_o = gnt;
    assign busy_o  = (state != IDLE);
    assign state_o = state;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt    <= pick_gnt;
                        state  <= BUSY;
                        wd_cnt <= '0;
                    end
                end
                BUSY, ERR: begin
                    if (!owner_cyc) begin
                        ptr    <= nxt_ptr;
                        wd_cnt <= '0;
                        if (pick_valid) begin
                            gnt   <= pick_gnt;
                            state <= BUSY;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (state == BUSY) begin
                        if (timeout_hit) begin
                            state  <= ERR;
                            wd_cnt <= '0;
                        end else if (s_ack_i || TIMEOUT == 0) begin
                            wd_cnt <= '0;
                        end else if (s_stb_o) begin
                            wd_cnt <= wd_cnt + TO_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed and random rounds of concurrent master
// requests, a latency-programmable slave, and a scoreboard fed by a round-robin model.
module tb_wishbone_arbiter;
    import wishbone_pkg::*;

    localparam int N     = 3;
    localparam int TMO   = 4;
    localparam int NEVER = 255;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*4-1:0]  m_sel_i;
    logic [N*32-1:0] m_adr_i, m_dat_i;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_gnt_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
    logic            s_ack_i, busy_o;
    arb_state_e      state_o;

    wishbone_arbiter #(.N_MASTER(N), .TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_gnt_o(m_gnt_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .busy_o(busy_o), .state_o(state_o)
    );

    typedef struct {
        int          mst;
        bit          err;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rd;
        logic [3:0]  sel;
        int          nxt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   model_ptr = 0;

    // Per-round transaction table, shared by master drivers and the slave.
    logic [N-1:0] t_act, t_we, t_nostb;
    logic [31:0]  t_adr[N], t_dat[N], t_rd[N];
    logic [3:0]   t_sel[N];
    int           t_lat[N], t_hold[N];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic clear_tab();
        t_act   = '0;
        t_nostb = '0;
        t_we    = '0;
    endtask

    task automatic set_txn(input int k, input logic [31:0] adr, input bit we, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rd, input int lat,
                           input int hold, input bit nostb);
        t_act[k] = 1'b1; t_adr[k] = adr; t_we[k] = we; t_dat[k] = dat; t_sel[k] = sel;
        t_rd[k] = rd; t_lat[k] = lat; t_hold[k] = hold; t_nostb[k] = nostb;
    endtask

    // Slave: acks the strobe whose address is in the table after t_lat wait cycles.
    initial begin
        int cnt;
        int lat;
        bit found;
        logic [31:0] rd;
        cnt = 0; lat = 0; rd = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (t_act[k] && !t_nostb[k] && t_adr[k] == s_adr_o) begin
                    found = 1'b1; lat = t_lat[k]; rd = t_rd[k];
                end
            end
            if (s_cyc_o && s_stb_o) begin
                if (found && cnt == lat) begin
                    s_ack_i = 1'b1; s_dat_i = rd; cnt = 0;
                end else begin
                    s_ack_i = 1'b0; s_dat_i = $urandom(); cnt++;
                end
            end else begin
                s_ack_i = 1'b0; s_dat_i = $urandom(); cnt = 0;
            end
        end
    end

    // Monitor: every ack/err the DUT presents is matched against the expected queue.
    initial begin
        exp_t e;
        int pend;
        pend = -1;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                pend = -1;
            end else begin
                if (pend >= 0) begin
                    check("handover_gnt", 32'(m_gnt_o), 1 << pend);
                    pend = -1;
                end
                if ((m_ack_o | m_err_o) != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {26'd0, m_ack_o, m_err_o}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_master", 32'(m_ack_o | m_err_o), 1 << e.mst);
                        check("resp_gnt", 32'(m_gnt_o), 1 << e.mst);
                        check("resp_err", 32'(|m_err_o), 32'(e.err));
                        check("resp_adr", s_adr_o, e.adr);
                        check("resp_we", 32'(s_we_o), 32'(e.we));
                        check("resp_sel", 32'(s_sel_o), 32'(e.sel));
                        if (e.we) check("resp_wdat", s_dat_o, e.dat);
                        if (!e.err && !e.we) check("resp_rdat", m_dat_o, e.rd);
                        pend = e.nxt;
                    end
                end
            end
        end
    end

    task automatic drive_master(input int k);
        int n;
        if (!t_act[k]) return;
        m_sel_i[k*4 +: 4]   = t_sel[k];
        m_adr_i[k*32 +: 32] = t_adr[k];
        m_dat_i[k*32 +: 32] = t_dat[k];
        m_we_i[k]  = t_we[k];
        m_stb_i[k] = !t_nostb[k];
        m_cyc_i[k] = 1'b1;
        n = 0;
        if (t_nostb[k]) begin
            do begin @(negedge clk); n++; end while (!m_gnt_o[k] && n < LIMIT);
            check("nostb_gnt_wait", 32'(n < LIMIT), 32'd1);
            @(negedge clk);
            check("nostb_held", {29'd0, s_stb_o, busy_o, m_gnt_o[k]}, 32'b011);
        end else begin
            do begin @(negedge clk); n++; end while (!(m_ack_o[k] || m_err_o[k]) && n < LIMIT);
            check("resp_wait", 32'(n < LIMIT), 32'd1);
            if (m_err_o[k]) begin
                for (int h = 0; h < t_hold[k]; h++) begin
                    @(negedge clk);
                    check("err_hold", {26'd0, s_cyc_o, s_stb_o, busy_o, m_gnt_o[k], |m_ack_o, |m_err_o},
                          32'b001100);
                end
            end
        end
        #1;
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
        m_we_i[k]  = 1'b0;
        m_sel_i[k*4 +: 4]   = '0;
        m_adr_i[k*32 +: 32] = '0;
        m_dat_i[k*32 +: 32] = '0;
    endtask

    // Reference: requesters raised together are served in cyclic order from ptr.
    task automatic run_round();
        int   order[$];
        exp_t e;
        int   k;
        for (int i = 0; i < N; i++) begin
            k = (model_ptr + i) % N;
            if (t_act[k]) order.push_back(k);
        end
        if (order.size() == 0) return;
        for (int i = 0; i < order.size(); i++) begin
            k = order[i];
            e.mst = k; e.err = (t_lat[k] >= TMO); e.we = t_we[k]; e.adr = t_adr[k];
            e.dat = t_dat[k]; e.rd = t_rd[k]; e.sel = t_sel[k];
            e.nxt = (i + 1 < order.size() && !e.err) ? order[i+1] : -1;
            if (!t_nostb[k]) exp_q.push_back(e);
        end
        model_ptr = (order[order.size()-1] + 1) % N;
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            automatic int kk = j;
            fork
                drive_master(kk);
            join_none
        end
        @(posedge clk);
        @(negedge clk);
        check("first_gnt", 32'(m_gnt_o), 1 << order[0]);
        check("first_cyc", 32'(s_cyc_o), 32'd1);
        wait fork;
    endtask

    task automatic rand_round();
        logic [31:0] r;
        int ls;
        clear_tab();
        t_act = N'($urandom_range(1, (1 << N) - 1));
        for (int k = 0; k < N; k++) begin
            if (t_act[k]) begin
                r  = $urandom();
                ls = $urandom_range(0, 5);
                set_txn(k, {r[31:4], 2'(k), 2'b00}, 1'($urandom_range(0, 1)), $urandom(),
                        4'($urandom_range(0, 15)), $urandom(), (ls == 5) ? NEVER : ls,
                        $urandom_range(1, 2), ($urandom_range(0, 7) == 0));
            end
        end
        run_round();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {15'd0, m_gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, busy_o},
              32'd0);
        check({tag, "_adr"}, s_adr_o, 32'd0);
        check({tag, "_wdat"}, s_dat_o, 32'd0);
        check({tag, "_rdat"}, m_dat_o, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
        clear_tab();
        for (int k = 0; k < N; k++) begin
            t_adr[k] = '0; t_dat[k] = '0; t_rd[k] = '0; t_sel[k] = '0; t_lat[k] = 0; t_hold[k] = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn_i = 1'b1;

        // Contention from reset: 0,1,2 then 0 again.
        clear_tab();
        for (int k = 0; k < N; k++)
            set_txn(k, 32'h100 + 32'(k * 4), 1'b0, 32'd0, 4'hF, 32'h1000 + 32'(k), 0, 1, 1'b0);
        run_round();
        clear_tab();
        set_txn(0, 32'h200, 1'b1, 32'h12345678, 4'h3, 32'd0, 0, 1, 1'b0);
        run_round();

        // Single write from master 1, slave acks one cycle late.
        clear_tab();
        set_txn(1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'd0, 1, 1, 1'b0);
        run_round();

        // Read from master 0.
        clear_tab();
        set_txn(0, 32'h4, 1'b0, 32'd0, 4'hF, 32'hCAFEF00D, 0, 1, 1'b0);
        run_round();

        // Watchdog fires, then ack landing exactly on the last counted cycle.
        clear_tab();
        set_txn(2, 32'h300, 1'b0, 32'd0, 4'hF, 32'd0, NEVER, 2, 1'b0);
        run_round();
        clear_tab();
        set_txn(1, 32'h304, 1'b0, 32'd0, 4'hF, 32'h0BADF00D, TMO - 1, 1, 1'b0);
        run_round();

        // Owner that never strobes.
        clear_tab();
        set_txn(2, 32'h400, 1'b0, 32'd0, 4'hF, 32'd0, 0, 1, 1'b1);
        set_txn(0, 32'h404, 1'b1, 32'h55AA55AA, 4'hC, 32'd0, 2, 1, 1'b0);
        run_round();

        for (int r = 0; r < 150; r++) rand_round();

        // Reset in the middle of an owned cycle.
        clear_tab();
        @(posedge clk);
        #1;
        m_cyc_i = 3'b011; m_stb_i = 3'b011; m_we_i = 3'b001;
        m_adr_i[31:0] = 32'h500; m_dat_i[31:0] = 32'hA5A5A5A5; m_sel_i[3:0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", {30'd0, busy_o, s_cyc_o}, 32'b11);
        #2;
        rstn_i = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        model_ptr = 0;
        clear_tab();
        for (int k = 0; k < N; k++)
            set_txn(k, 32'h600 + 32'(k * 4), 1'($urandom_range(0, 1)), $urandom(), 4'hF, $urandom(),
                    $urandom_range(0, 3), 1, 1'b0);
        run_round();
        for (int r = 0; r < 20; r++) rand_round();

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
